// File: rtl/ram_word_loader.sv
// Byte-stream to 64-bit word packer that fills consecutive RAM locations.
// Byte k of each word lands in bits [8k+7:8k]; all outputs are registered.
module ram_word_loader #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 8,
    parameter int MAX_ADDR = 225
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_write,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MAX_ADDR);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_n;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W:0]   last_addr;
    logic              cnt_zero;
    logic              range_bad;
    logic              accept;
    logic              xfer;
    logic              last_byte;

    // One bit wider than the address so a job running off the top never wraps.
    assign last_addr = {1'b0, base_addr} + {1'b0, word_count}
                     - {{ADDR_W{1'b0}}, 1'b1};
    assign cnt_zero  = (word_count == '0);
    assign range_bad = !cnt_zero && (last_addr > LIMIT);
    assign accept    = (state == IDLE) && start && !cnt_zero && !range_bad;
    assign xfer      = byte_valid && byte_ready;
    assign last_byte = (idx_q == IDX_W'(BYTES - 1));

    always_comb begin
        word_n = word_q;
        if (xfer)
            word_n[{idx_q, 3'b000} +: 8] = byte_in;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start && cnt_zero)
                    state_n = DONE;
                else if (accept)
                    state_n = COLLECT;
            end
            COLLECT: begin
                if (xfer && last_byte)
                    state_n = WRITE;
            end
            WRITE: begin
                state_n = (rem_q == ADDR_W'(1)) ? DONE : COLLECT;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_ready  <= 1'b0;
            ram_address <= '0;
            ram_in      <= '0;
            ram_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            word_q      <= '0;
            idx_q       <= '0;
        end else begin
            byte_ready <= (state_n == COLLECT);
            ram_write  <= (state_n == WRITE);
            busy       <= (state_n == COLLECT) || (state_n == WRITE);
            done       <= (state_n == DONE);
            error      <= (state == IDLE) && start && range_bad;
            if (accept) begin
                addr_q <= base_addr;
                rem_q  <= word_count;
                idx_q  <= '0;
            end
            if (xfer) begin
                word_q <= word_n;
                idx_q  <= last_byte ? '0 : idx_q + IDX_W'(1);
            end
            if (xfer && last_byte) begin
                ram_in      <= word_n;
                ram_address <= addr_q;
            end
            if (state == WRITE) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_word_loader.sv
// Directed bench for ram_word_loader: packing, range errors, resets,
// zero-length jobs and ignored starts.
module tb_ram_word_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  ram_address;
    logic [63:0] ram_in;
    logic        ram_write;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  wr_addr[$];
    logic [63:0] wr_data[$];
    int          wr_acc[$];
    int          acc_total = 0;
    int          back2back = 0;
    bit          prev_wr = 0;

    ram_word_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_write   (ram_write),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // Write log taken on the falling edge, where the RAM captures.
    always @(negedge clock) begin
        if (ram_write) begin
            wr_addr.push_back(ram_address);
            wr_data.push_back(ram_in);
            wr_acc.push_back(acc_total);
            if (prev_wr) back2back++;
        end
        prev_wr = ram_write;
        if (byte_valid && byte_ready) acc_total++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log;
        wr_addr.delete();
        wr_data.delete();
        wr_acc.delete();
    endtask

    task automatic start_job(input logic [7:0] b, input logic [7:0] c);
        start = 1;
        base_addr = b;
        word_count = c;
        tick;
        start = 0;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] first,
                              input bit toggle);
        int sent = 0;
        int cyc = 0;
        bit phase = 1;
        bit v;
        while (sent < n && cyc < 400) begin
            v = toggle ? phase : 1'b1;
            phase = ~phase;
            byte_valid = v;
            byte_in = first + 8'(sent);
            if (v && byte_ready) sent++;
            tick;
            cyc++;
        end
        byte_valid = 0;
        if (sent < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout sent=%0d want=%0d", sent, n);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({byte_ready, ram_write, busy, done, error} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_flags got=%b want=00000",
                     {byte_ready, ram_write, busy, done, error});
        end
        n_cmp++;
        if (ram_address !== 8'h00 || ram_in !== 64'h0) begin
            n_bad++;
            $display("FAIL rst_ram got=%h/%h want=00/0", ram_address, ram_in);
        end
        tick;
        reset = 0;
        tick;
        clear_log();
        start_job(8'h20, 8'd1);
        n_cmp++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_prebusy got=%b%b want=11", busy, byte_ready);
        end
        send_bytes(2, 8'hC0, 0);
        #3;
        reset = 1;
        #1;
        n_cmp++;
        if ({busy, byte_ready, ram_write} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_async got=%b want=000",
                     {busy, byte_ready, ram_write});
        end
        tick;
        reset = 0;
        tick;
    endtask

    task automatic test_stream(input bit toggle);
        int acc0;
        int b0;
        clear_log();
        acc0 = acc_total;
        b0 = back2back;
        start_job(8'h10, 8'd2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stream%0d_busy got=%b want=1", toggle, busy);
        end
        send_bytes(16, 8'h01, toggle);
        n_cmp++;
        if (ram_write !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL stream%0d_lastwr got=%b%b want=10",
                     toggle, ram_write, done);
        end
        tick;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stream%0d_done got=%b%b want=10", toggle, done, busy);
        end
        tick;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL stream%0d_donepulse got=%b want=0", toggle, done);
        end
        n_cmp++;
        if (wr_addr.size() !== 2) begin
            n_bad++;
            $display("FAIL stream%0d_nwr got=%0d want=2", toggle, wr_addr.size());
        end
        n_cmp++;
        if (wr_addr[0] !== 8'h10 || wr_data[0] !== 64'h0807060504030201) begin
            n_bad++;
            $display("FAIL stream%0d_w0 got=%h:%h want=10:0807060504030201",
                     toggle, wr_addr[0], wr_data[0]);
        end
        n_cmp++;
        if (wr_addr[1] !== 8'h11 || wr_data[1] !== 64'h100F0E0D0C0B0A09) begin
            n_bad++;
            $display("FAIL stream%0d_w1 got=%h:%h want=11:100F0E0D0C0B0A09",
                     toggle, wr_addr[1], wr_data[1]);
        end
        n_cmp++;
        if (wr_acc[0] !== acc0 + 8 || wr_acc[1] !== acc0 + 16) begin
            n_bad++;
            $display("FAIL stream%0d_wrorder got=%0d,%0d want=%0d,%0d", toggle,
                     wr_acc[0] - acc0, wr_acc[1] - acc0, 8, 16);
        end
        n_cmp++;
        if (back2back !== b0) begin
            n_bad++;
            $display("FAIL stream%0d_b2b got=%0d want=%0d", toggle, back2back, b0);
        end
    endtask

    task automatic test_range;
        clear_log();
        start_job(8'hE0, 8'd3);
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL range_err got=%b%b%b want=100", error, busy, byte_ready);
        end
        tick;
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL range_pulse got=%b%b want=00", error, busy);
        end
        start_job(8'hE0, 8'd2);
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL range_ok got=%b%b want=01", error, busy);
        end
        send_bytes(16, 8'hA0, 0);
        repeat (2) tick;
        n_cmp++;
        if (wr_addr.size() !== 2 || wr_addr[0] !== 8'hE0 || wr_addr[1] !== 8'hE1) begin
            n_bad++;
            $display("FAIL range_addr got=%0d:%h,%h want=2:e0,e1",
                     wr_addr.size(), wr_addr[0], wr_addr[1]);
        end
        n_cmp++;
        if (wr_data[0] !== 64'hA7A6A5A4A3A2A1A0 || wr_data[1] !== 64'hAFAEADACABAAA9A8) begin
            n_bad++;
            $display("FAIL range_data got=%h,%h want=a7a6a5a4a3a2a1a0,afaeadacabaaa9a8",
                     wr_data[0], wr_data[1]);
        end
    endtask

    task automatic test_reset_mid;
        clear_log();
        start_job(8'h30, 8'd2);
        send_bytes(5, 8'h77, 0);
        reset = 1;
        #2;
        tick;
        reset = 0;
        tick;
        n_cmp++;
        if (wr_addr.size() !== 0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst got=%0d,%b%b want=0,00",
                     wr_addr.size(), busy, byte_ready);
        end
        start_job(8'h00, 8'd1);
        send_bytes(8, 8'h55, 0);
        repeat (2) tick;
        n_cmp++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 8'h00 ||
            wr_data[0] !== 64'h5C5B5A5958575655) begin
            n_bad++;
            $display("FAIL midrst_fresh got=%0d,%h:%h want=1,00:5c5b5a5958575655",
                     wr_addr.size(), wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_zero_and_ignore;
        bit seen_done = 0;
        clear_log();
        start_job(8'h40, 8'd0);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_done got=%b%b%b want=100", done, busy, byte_ready);
        end
        tick;
        n_cmp++;
        if (done !== 1'b0 || wr_addr.size() !== 0) begin
            n_bad++;
            $display("FAIL zero_after got=%b,%0d want=0,0", done, wr_addr.size());
        end
        start_job(8'h50, 8'd1);
        send_bytes(3, 8'h11, 0);
        start_job(8'h90, 8'd5);
        send_bytes(5, 8'h14, 0);
        for (int i = 0; i < 3; i++) begin
            if (done) seen_done = 1;
            tick;
        end
        n_cmp++;
        if (seen_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_done got=%b,%b want=1,0", seen_done, busy);
        end
        n_cmp++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 8'h50 ||
            wr_data[0] !== 64'h1817161514131211) begin
            n_bad++;
            $display("FAIL ignore_wr got=%0d,%h:%h want=1,50:1817161514131211",
                     wr_addr.size(), wr_addr[0], wr_data[0]);
        end
    endtask

    initial begin
        reset = 1;
        start = 0;
        base_addr = 0;
        word_count = 0;
        byte_in = 0;
        byte_valid = 0;
        tick;
        test_reset();
        test_stream(0);
        test_stream(1);
        test_range();
        test_reset_mid();
        test_zero_and_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
